store_tag_alloc_mw: RTL and testbench

Multi-way store-tag allocator for the superscalar dispatch/rename stage. It holds a busy vector of TAG_DEPTH store tags and grants up to ALLOC_WIDTH tags per cycle to dispatching stores. It accepts up to FREE_WIDTH tag releases per cycle from writeback/commit. It keeps CKPT_DEPTH branch checkpoints of the busy vector internally, so a mispredict recovers the vector without an external copy.

---
 rtl/store_tag_alloc_mw.sv | 133 +++++++++++++
 tb/tb_store_tag_alloc_mw.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_tag_alloc_mw.sv
// Multi-way store-tag allocator: in-order grants from a busy vector, multi-port
// release, and internal branch checkpoints of the busy vector for mispredict recovery.
module store_tag_alloc_mw #(
    parameter int unsigned TAG_DEPTH   = 16,
    parameter int unsigned ALLOC_WIDTH = 2,
    parameter int unsigned FREE_WIDTH  = 2,
    parameter int unsigned CKPT_DEPTH  = 4,
    localparam int unsigned TW   = $clog2(TAG_DEPTH),
    localparam int unsigned CW   = $clog2(CKPT_DEPTH),
    localparam int unsigned LW   = $clog2(ALLOC_WIDTH + 1),
    localparam int unsigned CNTW = TW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ALLOC_WIDTH-1:0]      alloc_req,
    output logic [ALLOC_WIDTH-1:0]      alloc_gnt,
    output logic [ALLOC_WIDTH*TW-1:0]   alloc_tag,
    input  logic [FREE_WIDTH-1:0]       free_valid,
    input  logic [FREE_WIDTH*TW-1:0]    free_tag,
    input  logic                        ckpt_save,
    input  logic [CW-1:0]               ckpt_id,
    input  logic [LW-1:0]               ckpt_lane,
    input  logic                        flush,
    input  logic [CW-1:0]               flush_id,
    output logic [TAG_DEPTH-1:0]        busy_vec,
    output logic [CNTW-1:0]             free_count,
    output logic                        empty,
    output logic                        full
);

    logic [TAG_DEPTH-1:0] busy_q;
    logic [TAG_DEPTH-1:0] busy_next;
    logic [TAG_DEPTH-1:0] freed_mask;
    logic [TAG_DEPTH-1:0] grant_mask;
    logic [TAG_DEPTH-1:0] older_mask;
    logic [TAG_DEPTH-1:0] avail;
    logic [TAG_DEPTH-1:0] ckpt_q [CKPT_DEPTH];
    logic [CNTW-1:0]      count_next;
    logic [TW-1:0]        pick;
    logic                 found;
    logic                 blocked;

    function automatic logic [CNTW-1:0] popcnt(input logic [TAG_DEPTH-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int b = 0; b < TAG_DEPTH; b++) begin
            n = n + CNTW'(v[b]);
        end
        return n;
    endfunction

    assign busy_vec = busy_q;

    // In-order lane scan: each granted lane takes the lowest tag still available
    always_comb begin
        avail      = ~busy_q;
        blocked    = 1'b0;
        found      = 1'b0;
        pick       = '0;
        alloc_gnt  = '0;
        alloc_tag  = '0;
        grant_mask = '0;
        older_mask = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            found = 1'b0;
            pick  = '0;
            for (int j = 0; j < TAG_DEPTH; j++) begin
                if (!found && avail[j]) begin
                    found = 1'b1;
                    pick  = TW'(j);
                end
            end
            if (alloc_req[i] && !blocked && !rst && !flush) begin
                if (found) begin
                    alloc_gnt[i]          = 1'b1;
                    alloc_tag[i*TW +: TW] = pick;
                    avail[pick]           = 1'b0;
                    grant_mask[pick]      = 1'b1;
                    if (LW'(i) < ckpt_lane) begin
                        older_mask[pick] = 1'b1;
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_comb begin
        freed_mask = '0;
        for (int p = 0; p < FREE_WIDTH; p++) begin
            if (free_valid[p]) begin
                freed_mask[free_tag[p*TW +: TW]] = 1'b1;
            end
        end
    end

    // Restore intersects with busy_q so tags released since the save stay free
    always_comb begin
        if (flush) begin
            busy_next  = ckpt_q[flush_id] & busy_q & ~freed_mask;
            count_next = CNTW'(TAG_DEPTH) - popcnt(busy_next);
        end else begin
            busy_next  = (busy_q & ~freed_mask) | grant_mask;
            count_next = free_count + popcnt(busy_q & freed_mask) - popcnt(grant_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            free_count <= CNTW'(TAG_DEPTH);
            empty      <= 1'b1;
            full       <= 1'b0;
            for (int k = 0; k < CKPT_DEPTH; k++) begin
                ckpt_q[k] <= '0;
            end
        end else begin
            busy_q     <= busy_next;
            free_count <= count_next;
            empty      <= (busy_next == '0);
            full       <= &busy_next;
            for (int k = 0; k < CKPT_DEPTH; k++) begin
                if (!flush && ckpt_save && (ckpt_id == CW'(k))) begin
                    ckpt_q[k] <= (busy_q | older_mask) & ~freed_mask;
                end else begin
                    ckpt_q[k] <= ckpt_q[k] & ~freed_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_tag_alloc_mw.sv
// Scoreboard bench for store_tag_alloc_mw: a set/list-level reference model queues
// expected grants and post-edge state; independent monitors compare them.
module tb_store_tag_alloc_mw;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_req;
    logic [1:0]  alloc_gnt;
    logic [7:0]  alloc_tag;
    logic [1:0]  free_valid;
    logic [7:0]  free_tag;
    logic        ckpt_save;
    logic [1:0]  ckpt_id;
    logic [1:0]  ckpt_lane;
    logic        flush;
    logic [1:0]  flush_id;
    logic [15:0] busy_vec;
    logic [4:0]  free_count;
    logic        empty;
    logic        full;

    always #5 clk = ~clk;

    store_tag_alloc_mw #(
        .TAG_DEPTH(16), .ALLOC_WIDTH(2), .FREE_WIDTH(2), .CKPT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .free_valid(free_valid), .free_tag(free_tag),
        .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .ckpt_lane(ckpt_lane),
        .flush(flush), .flush_id(flush_id),
        .busy_vec(busy_vec), .free_count(free_count), .empty(empty), .full(full)
    );

    typedef struct packed {
        logic [1:0] gnt;
        logic [7:0] tag;
    } gexp_t;

    typedef struct packed {
        logic [15:0] busy;
        logic [4:0]  cnt;
        logic        empty;
        logic        full;
    } sexp_t;

    gexp_t       gq[$];
    sexp_t       sq[$];
    logic [15:0] m_busy;
    logic [15:0] m_ckpt [4];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Drive one cycle and advance the reference model
    task automatic cycle(input logic r, input logic [1:0] req, input logic [1:0] fv,
                         input logic [3:0] t0, input logic [3:0] t1, input logic sv,
                         input logic [1:0] sid, input logic [1:0] sl, input logic fl,
                         input logic [1:0] fid);
        gexp_t       g;
        sexp_t       s;
        logic [15:0] freed;
        logic [15:0] older;
        logic [15:0] gmask;
        logic [15:0] nb;
        int          free_list[$];
        int          pos;
        bit          stop;
        @(negedge clk);
        rst = r; alloc_req = req; free_valid = fv; free_tag = {t1, t0};
        ckpt_save = sv; ckpt_id = sid; ckpt_lane = sl; flush = fl; flush_id = fid;
        g = '0;
        if (r) begin
            m_busy = '0;
            for (int k = 0; k < 4; k++) m_ckpt[k] = '0;
        end else begin
            freed = '0;
            if (fv[0]) freed[t0] = 1'b1;
            if (fv[1]) freed[t1] = 1'b1;
            older = '0;
            gmask = '0;
            if (!fl) begin
                for (int t = 0; t < 16; t++) if (!m_busy[t]) free_list.push_back(t);
                pos  = 0;
                stop = 0;
                for (int l = 0; l < 2; l++) begin
                    if (req[l] && !stop) begin
                        if (pos < free_list.size()) begin
                            g.gnt[l]          = 1'b1;
                            g.tag[l*4 +: 4]   = 4'(free_list[pos]);
                            gmask[free_list[pos]] = 1'b1;
                            if (l < int'(sl)) older[free_list[pos]] = 1'b1;
                            pos++;
                        end else begin
                            stop = 1;
                        end
                    end
                end
            end
            nb = fl ? (m_ckpt[fid] & m_busy & ~freed) : ((m_busy & ~freed) | gmask);
            if (!fl && sv) m_ckpt[sid] = m_busy | older;
            for (int k = 0; k < 4; k++) m_ckpt[k] = m_ckpt[k] & ~freed;
            m_busy = nb;
        end
        s.busy  = m_busy;
        s.cnt   = 5'(16 - $countones(m_busy));
        s.empty = (m_busy == 16'h0);
        s.full  = (m_busy == 16'hFFFF);
        gq.push_back(g);
        sq.push_back(s);
    endtask

    task automatic rand_cycle();
        logic [3:0] t[2];
        logic [1:0] fv;
        int         st;
        for (int p = 0; p < 2; p++) begin
            t[p] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                st = $urandom_range(0, 15);
                for (int i = 15; i >= 0; i--) if (m_busy[(st + i) % 16]) t[p] = 4'((st + i) % 16);
            end
        end
        fv = 2'($urandom_range(0, 3));
        cycle(($urandom_range(0, 999) == 0), 2'($urandom_range(0, 3)), fv, t[0], t[1],
              ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)));
    endtask

    // Grant monitor: combinational outputs, sampled mid-cycle
    initial begin : gnt_mon
        gexp_t g;
        forever begin
            @(negedge clk);
            #2;
            if (gq.size() > 0) begin
                g = gq.pop_front();
                check("alloc_gnt", 32'(alloc_gnt), 32'(g.gnt));
                check("alloc_tag", 32'(alloc_tag), 32'(g.tag));
            end
        end
    end

    // State monitor: registered outputs, sampled just after the edge
    initial begin : state_mon
        sexp_t s;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                check("busy_vec", 32'(busy_vec), 32'(s.busy));
                check("free_count", 32'(free_count), 32'(s.cnt));
                check("empty", 32'(empty), 32'(s.empty));
                check("full", 32'(full), 32'(s.full));
                check("count_invariant", 32'(free_count), 32'(16 - $countones(busy_vec)));
            end
        end
    end

    initial begin
        rst = 1'b1; alloc_req = '0; free_valid = '0; free_tag = '0;
        ckpt_save = 1'b0; ckpt_id = '0; ckpt_lane = '0; flush = 1'b0; flush_id = '0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        #3 check("gnt_in_reset", 32'(alloc_gnt), 32'h0);

        // Fill in pairs
        for (int i = 0; i < 8; i++) cycle(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("fill_full", 32'(full), 32'h1);
        check("fill_count", 32'(free_count), 32'h0);
        cycle(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        #3 check("gnt_when_full", 32'(alloc_gnt), 32'h0);

        // Single free tag: lane 0 only
        cycle(0, 2'b00, 2'b01, 4'd0, 0, 0, 0, 0, 0, 0);
        cycle(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        #3 check("one_free_gnt", 32'(alloc_gnt), 32'h1);
        check("one_free_tag", 32'(alloc_tag[3:0]), 32'h0);
        cycle(0, 2'b10, 2'b01, 4'd5, 0, 0, 0, 0, 0, 0);
        #3 check("same_cycle_free_gnt", 32'(alloc_gnt), 32'h0);
        cycle(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        #3 check("reuse_tag5", 32'(alloc_tag[3:0]), 32'h5);

        // Checkpoint with a split alloc group, then restore
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 2'b11, 0, 0, 0, 1, 2'd1, 2'd1, 0, 0);
        cycle(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 check("pre_flush_busy", 32'(busy_vec), 32'hFF);
        cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'd1);
        @(posedge clk); #1;
        check("restore_busy", 32'(busy_vec), 32'h1F);
        check("restore_count", 32'(free_count), 32'd11);

        // Released tag must not come back on restore
        cycle(0, 2'b00, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0);
        cycle(0, 2'b00, 2'b01, 4'd2, 0, 0, 0, 0, 0, 0);
        cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'd2);
        @(posedge clk); #1 check("no_resurrect", 32'(busy_vec), 32'h1B);

        // Flush beats alloc and save; same-cycle free still applies
        cycle(0, 2'b11, 2'b01, 4'd0, 0, 1, 2'd3, 2'd2, 1, 2'd2);
        #3 check("flush_gnt", 32'(alloc_gnt), 32'h0);
        @(posedge clk); #1 check("flush_free_busy", 32'(busy_vec), 32'h1A);
        cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'd3);
        @(posedge clk); #1 check("save_ignored", 32'(empty), 32'h1);

        for (int i = 0; i < 10000; i++) rand_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && (sq.size() > 0 || gq.size() > 0); i++) @(posedge clk);
        #3;
        checks++;
        if (sq.size() > 0 || gq.size() > 0) begin
            failures++;
            $display("FAIL drain pending_state=%0d pending_gnt=%0d expected=0", sq.size(), gq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
